// File: rtl/ct_had_event_mc.sv
// rtl/ct_had_event_mc.sv - multi-channel HAD cross-trigger debug event unit
module ct_had_event_mc #(
  parameter int CH_NUM      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int PULSE_W     = 4
) (
  input  logic              cpuclk,
  input  logic              cpurst,
  input  logic [CH_NUM-1:0] x_enter_dbg_req_i,
  input  logic [CH_NUM-1:0] x_exit_dbg_req_i,
  input  logic [CH_NUM-1:0] regs_event_enter_ie,
  input  logic [CH_NUM-1:0] regs_event_exit_ie,
  input  logic [CH_NUM-1:0] regs_event_enter_oe,
  input  logic [CH_NUM-1:0] regs_event_exit_oe,
  input  logic              ctrl_event_dbgenter,
  input  logic              ctrl_event_dbgexit,
  input  logic              rtu_yy_xx_dbgon,
  output logic              event_ctrl_enter_dbg,
  output logic              event_ctrl_exit_dbg,
  output logic [CH_NUM-1:0] event_regs_enter_src,
  output logic              event_ctrl_had_clk_en,
  output logic [CH_NUM-1:0] x_enter_dbg_req_o,
  output logic [CH_NUM-1:0] x_exit_dbg_req_o
);

  localparam int CNT_W = $clog2(PULSE_W + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_W);

  // Stage 0 takes the raw async level, stage SYNC_STAGES-1 is the safe copy.
  logic [SYNC_STAGES-1:0][CH_NUM-1:0] enter_sync;
  logic [SYNC_STAGES-1:0][CH_NUM-1:0] exit_sync;
  logic [CH_NUM-1:0] enter_lvl;
  logic [CH_NUM-1:0] exit_lvl;
  logic [CH_NUM-1:0] enter_prev;
  logic [CH_NUM-1:0] exit_prev;
  logic [CH_NUM-1:0] enter_masked;
  logic [CH_NUM-1:0] exit_masked;
  logic              enter_hit;
  logic              exit_hit;
  logic              enter_pending;
  logic [CNT_W-1:0]  enter_cnt;
  logic [CNT_W-1:0]  exit_cnt;

  assign enter_lvl    = enter_sync[SYNC_STAGES-1];
  assign exit_lvl     = exit_sync[SYNC_STAGES-1];
  assign enter_masked = enter_lvl & ~enter_prev & regs_event_enter_ie;
  assign exit_masked  = exit_lvl & ~exit_prev & regs_event_exit_ie;
  assign enter_hit    = |enter_masked;
  assign exit_hit     = |exit_masked;

  // Synchroniser chains for the inbound request levels
  always_ff @(posedge cpuclk or posedge cpurst) begin
    if (cpurst) begin
      enter_sync <= '0;
      exit_sync  <= '0;
    end else begin
      enter_sync <= {enter_sync[SYNC_STAGES-2:0], x_enter_dbg_req_i};
      exit_sync  <= {exit_sync[SYNC_STAGES-2:0], x_exit_dbg_req_i};
    end
  end

  // Previous synchronised level; a level high at reset release counts as one edge
  always_ff @(posedge cpuclk or posedge cpurst) begin
    if (cpurst) begin
      enter_prev <= '0;
      exit_prev  <= '0;
    end else begin
      enter_prev <= enter_lvl;
      exit_prev  <= exit_lvl;
    end
  end

  // Sticky enter request and its source channels; hits while in debug are dropped
  always_ff @(posedge cpuclk or posedge cpurst) begin
    if (cpurst) begin
      enter_pending        <= 1'b0;
      event_regs_enter_src <= '0;
    end else if (enter_hit && !rtu_yy_xx_dbgon) begin
      enter_pending        <= 1'b1;
      event_regs_enter_src <= enter_pending ? (event_regs_enter_src | enter_masked)
                                            : enter_masked;
    end else if (rtu_yy_xx_dbgon) begin
      enter_pending        <= 1'b0;
    end
  end

  // One-cycle exit request, only meaningful while the core is in debug
  always_ff @(posedge cpuclk or posedge cpurst) begin
    if (cpurst) begin
      event_ctrl_exit_dbg <= 1'b0;
    end else begin
      event_ctrl_exit_dbg <= exit_hit & rtu_yy_xx_dbgon;
    end
  end

  // Outbound pulse stretchers; a reload mid-pulse restarts the count
  always_ff @(posedge cpuclk or posedge cpurst) begin
    if (cpurst) begin
      enter_cnt <= '0;
      exit_cnt  <= '0;
    end else begin
      if (ctrl_event_dbgenter) begin
        enter_cnt <= CNT_LOAD;
      end else if (enter_cnt != '0) begin
        enter_cnt <= enter_cnt - CNT_W'(1);
      end
      if (ctrl_event_dbgexit) begin
        exit_cnt <= CNT_LOAD;
      end else if (exit_cnt != '0) begin
        exit_cnt <= exit_cnt - CNT_W'(1);
      end
    end
  end

  assign event_ctrl_enter_dbg  = enter_pending;
  assign x_enter_dbg_req_o     = {CH_NUM{enter_cnt != '0}} & regs_event_enter_oe;
  assign x_exit_dbg_req_o      = {CH_NUM{exit_cnt != '0}} & regs_event_exit_oe;
  assign event_ctrl_had_clk_en = (|enter_lvl) | (|exit_lvl) | enter_pending
                               | (enter_cnt != '0) | (exit_cnt != '0);

endmodule

// File: tb/tb_ct_had_event_mc.sv
// tb/tb_ct_had_event_mc.sv - directed vector bench for ct_had_event_mc
module tb_ct_had_event_mc;

  logic       cpuclk = 1'b0;
  logic       cpurst = 1'b1;
  logic [3:0] en_i = '0, ex_i = '0, en_ie = '0, ex_ie = '0, en_oe = '0, ex_oe = '0;
  logic       dgen = 1'b0, dgex = 1'b0, dbgon = 1'b0;
  logic       enter_dbg, exit_dbg, clk_en;
  logic [3:0] src, xen_o, xex_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 cpuclk = ~cpuclk;

  ct_had_event_mc #(.CH_NUM(4), .SYNC_STAGES(2), .PULSE_W(4)) dut (
    .cpuclk                (cpuclk),
    .cpurst                (cpurst),
    .x_enter_dbg_req_i     (en_i),
    .x_exit_dbg_req_i      (ex_i),
    .regs_event_enter_ie   (en_ie),
    .regs_event_exit_ie    (ex_ie),
    .regs_event_enter_oe   (en_oe),
    .regs_event_exit_oe    (ex_oe),
    .ctrl_event_dbgenter   (dgen),
    .ctrl_event_dbgexit    (dgex),
    .rtu_yy_xx_dbgon       (dbgon),
    .event_ctrl_enter_dbg  (enter_dbg),
    .event_ctrl_exit_dbg   (exit_dbg),
    .event_regs_enter_src  (src),
    .event_ctrl_had_clk_en (clk_en),
    .x_enter_dbg_req_o     (xen_o),
    .x_exit_dbg_req_o      (xex_o)
  );

  typedef struct {
    logic [3:0] en_i, ex_i, en_ie, ex_ie, en_oe, ex_oe;
    logic       dgen, dgex, dbgon;
    logic       e_enter, e_exit;
    logic [3:0] e_src, e_xen, e_xex;
    logic       e_clk;
  } vec_t;

  vec_t vecs[27];

  function automatic vec_t mk(input logic [3:0] ei, xi, eoe, input logic dge, dgx, dbg,
                              input logic ee, ex, input logic [3:0] es, exn, exx,
                              input logic ec);
    vec_t v;
    v.en_i = ei; v.ex_i = xi; v.en_ie = 4'b0101; v.ex_ie = 4'b1111;
    v.en_oe = eoe; v.ex_oe = 4'b1100; v.dgen = dge; v.dgex = dgx; v.dbgon = dbg;
    v.e_enter = ee; v.e_exit = ex; v.e_src = es; v.e_xen = exn; v.e_xex = exx; v.e_clk = ec;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge cpuclk);
    #1;
  endtask

  initial begin
    int hits;
    int first;

    //            en_i   ex_i   en_oe  dge dgx dbg  ent ext src    xen    xex    clk
    vecs[0]  = mk(4'h4, 4'h0, 4'h3, 0, 0, 0,   0, 0, 4'h0, 4'h0, 4'h0, 0);
    vecs[1]  = mk(4'h4, 4'h0, 4'h3, 0, 0, 0,   0, 0, 4'h0, 4'h0, 4'h0, 1);
    vecs[2]  = mk(4'h4, 4'h0, 4'h3, 0, 0, 0,   1, 0, 4'h4, 4'h0, 4'h0, 1);
    vecs[3]  = mk(4'h6, 4'h0, 4'h3, 0, 0, 0,   1, 0, 4'h4, 4'h0, 4'h0, 1);
    vecs[4]  = mk(4'h6, 4'h0, 4'h3, 0, 0, 0,   1, 0, 4'h4, 4'h0, 4'h0, 1);
    vecs[5]  = mk(4'h7, 4'h0, 4'h3, 0, 0, 0,   1, 0, 4'h4, 4'h0, 4'h0, 1);
    vecs[6]  = mk(4'h7, 4'h0, 4'h3, 0, 0, 0,   1, 0, 4'h4, 4'h0, 4'h0, 1);
    vecs[7]  = mk(4'h7, 4'h0, 4'h3, 0, 0, 0,   1, 0, 4'h5, 4'h0, 4'h0, 1);
    vecs[8]  = mk(4'h7, 4'h0, 4'h3, 0, 0, 1,   0, 0, 4'h5, 4'h0, 4'h0, 1);
    vecs[9]  = mk(4'h0, 4'h8, 4'h3, 0, 0, 1,   0, 0, 4'h5, 4'h0, 4'h0, 1);
    vecs[10] = mk(4'h0, 4'h8, 4'h3, 0, 0, 1,   0, 0, 4'h5, 4'h0, 4'h0, 1);
    vecs[11] = mk(4'h0, 4'h8, 4'h3, 0, 0, 1,   0, 1, 4'h5, 4'h0, 4'h0, 1);
    vecs[12] = mk(4'h0, 4'h8, 4'h3, 0, 0, 1,   0, 0, 4'h5, 4'h0, 4'h0, 1);
    vecs[13] = mk(4'h0, 4'h0, 4'h3, 0, 0, 1,   0, 0, 4'h5, 4'h0, 4'h0, 1);
    vecs[14] = mk(4'h0, 4'h0, 4'h3, 0, 0, 1,   0, 0, 4'h5, 4'h0, 4'h0, 0);
    vecs[15] = mk(4'h0, 4'h0, 4'h3, 1, 0, 0,   0, 0, 4'h5, 4'h3, 4'h0, 1);
    vecs[16] = mk(4'h0, 4'h0, 4'h3, 0, 0, 0,   0, 0, 4'h5, 4'h3, 4'h0, 1);
    vecs[17] = mk(4'h0, 4'h0, 4'h3, 1, 0, 0,   0, 0, 4'h5, 4'h3, 4'h0, 1);
    vecs[18] = mk(4'h0, 4'h0, 4'h3, 0, 0, 0,   0, 0, 4'h5, 4'h3, 4'h0, 1);
    vecs[19] = mk(4'h0, 4'h0, 4'h3, 0, 0, 0,   0, 0, 4'h5, 4'h3, 4'h0, 1);
    vecs[20] = mk(4'h0, 4'h0, 4'h3, 0, 0, 0,   0, 0, 4'h5, 4'h3, 4'h0, 1);
    vecs[21] = mk(4'h0, 4'h0, 4'h3, 0, 0, 0,   0, 0, 4'h5, 4'h0, 4'h0, 0);
    vecs[22] = mk(4'h0, 4'h0, 4'h3, 1, 1, 0,   0, 0, 4'h5, 4'h3, 4'hC, 1);
    vecs[23] = mk(4'h0, 4'h0, 4'h3, 0, 0, 0,   0, 0, 4'h5, 4'h3, 4'hC, 1);
    vecs[24] = mk(4'h0, 4'h0, 4'h1, 0, 0, 0,   0, 0, 4'h5, 4'h1, 4'hC, 1);
    vecs[25] = mk(4'h0, 4'h0, 4'h3, 0, 0, 0,   0, 0, 4'h5, 4'h3, 4'hC, 1);
    vecs[26] = mk(4'h0, 4'h0, 4'h3, 0, 0, 0,   0, 0, 4'h5, 4'h0, 4'h0, 0);

    // Reset state
    repeat (3) @(posedge cpuclk);
    #1;
    chk("rst_enter", {3'b0, enter_dbg}, 4'h0);
    chk("rst_exit",  {3'b0, exit_dbg},  4'h0);
    chk("rst_src",   src,   4'h0);
    chk("rst_xen",   xen_o, 4'h0);
    chk("rst_xex",   xex_o, 4'h0);
    chk("rst_clk",   {3'b0, clk_en}, 4'h0);
    cpurst = 1'b0;

    // Cycle-by-cycle vectors
    for (int i = 0; i < 27; i++) begin
      en_i = vecs[i].en_i; ex_i = vecs[i].ex_i; en_ie = vecs[i].en_ie; ex_ie = vecs[i].ex_ie;
      en_oe = vecs[i].en_oe; ex_oe = vecs[i].ex_oe;
      dgen = vecs[i].dgen; dgex = vecs[i].dgex; dbgon = vecs[i].dbgon;
      step();
      chk($sformatf("v%0d_enter", i), {3'b0, enter_dbg}, {3'b0, vecs[i].e_enter});
      chk($sformatf("v%0d_exit", i),  {3'b0, exit_dbg},  {3'b0, vecs[i].e_exit});
      chk($sformatf("v%0d_src", i),   src,   vecs[i].e_src);
      chk($sformatf("v%0d_xen", i),   xen_o, vecs[i].e_xen);
      chk($sformatf("v%0d_xex", i),   xex_o, vecs[i].e_xex);
      chk($sformatf("v%0d_clk", i),   {3'b0, clk_en}, {3'b0, vecs[i].e_clk});
    end
    dgen = 1'b0; dgex = 1'b0;

    // Exit level held 20 cycles in debug: one pulse, third edge after raise
    dbgon = 1'b1; ex_i = 4'h8; hits = 0; first = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (exit_dbg) begin
        hits++;
        if (first == 0) first = k;
      end
    end
    chk("exit_hold_count", 4'(hits), 4'h1);
    chk("exit_hold_first", 4'(first), 4'h3);
    ex_i = 4'h0;
    repeat (4) step();

    // Same stimulus outside debug: dropped
    dbgon = 1'b0; ex_i = 4'h8; hits = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (exit_dbg) hits++;
    end
    chk("exit_nodbg_count", 4'(hits), 4'h0);
    ex_i = 4'h0;
    repeat (4) step();

    // Enter edge while in debug is never recorded, even after leaving debug
    dbgon = 1'b1; en_i = 4'h1;
    repeat (5) step();
    chk("enter_in_dbg", {3'b0, enter_dbg}, 4'h0);
    chk("enter_in_dbg_src", src, 4'h5);
    dbgon = 1'b0;
    repeat (3) step();
    chk("enter_after_dbg", {3'b0, enter_dbg}, 4'h0);
    en_i = 4'h0;
    repeat (4) step();

    // Fresh set overwrites the old source, then async reset mid-pulse
    en_i = 4'h4;
    repeat (3) step();
    chk("reload_enter", {3'b0, enter_dbg}, 4'h1);
    chk("reload_src", src, 4'h4);
    dgen = 1'b1; dgex = 1'b1;
    step();
    dgen = 1'b0; dgex = 1'b0;
    chk("pre_rst_xen", xen_o, 4'h3);
    #3 cpurst = 1'b1;
    #1;
    chk("arst_enter", {3'b0, enter_dbg}, 4'h0);
    chk("arst_src",   src,   4'h0);
    chk("arst_xen",   xen_o, 4'h0);
    chk("arst_xex",   xex_o, 4'h0);
    chk("arst_clk",   {3'b0, clk_en}, 4'h0);
    repeat (2) step();
    cpurst = 1'b0;

    // Level held across reset release yields one enter after three edges
    step();
    chk("rel_e1_enter", {3'b0, enter_dbg}, 4'h0);
    step();
    chk("rel_e2_enter", {3'b0, enter_dbg}, 4'h0);
    chk("rel_e2_clk", {3'b0, clk_en}, 4'h1);
    step();
    chk("rel_e3_enter", {3'b0, enter_dbg}, 4'h1);
    chk("rel_e3_src", src, 4'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
